cus19_instr_mem_ld: RTL and testbench
=====================================

# cus19_instr_mem_ld

Parametrised instruction memory for the Custom19 IF stage, superseding the testbench-loaded memory. It adds an on-chip program-load port (valid/ready stream with base and length), fetch-side stall/flush control, output valid, and range checking for a memory shallower than the PC space. It sits between the PC register and the IF/ID pipeline register. The same program-load port is used by the boot loader and by the testbench.

## Interface
Parameters:
- PC_Width, 11, PC / address width
- Instr_Width, 19, instruction width
- Mem_Depth, 2048, implemented words; must satisfy 1 ≤ Mem_Depth ≤ 2^PC_Width
- NOP_Instr, 0, word driven on flush or out-of-range fetch

Ports:
- clk_in  input  1  single clock, all logic on rising edge
- rst_in  input  1  synchronous, active-high reset
- pc_in  input  PC_Width  fetch address
- fetch_en_in  input  1  request fetch of mem[pc_in]
- stall_in  input  1  hold instruction output and valid
- flush_in  input  1  kill output: NOP, valid low
- cus19_instr_out  output  Instr_Width  registered instruction
- instr_valid_out  output  1  cus19_instr_out holds a fetched word
- fetch_err_out  output  1  one-cycle pulse: out-of-range fetch
- ld_start_in  input  1  begin a load burst
- ld_base_in  input  PC_Width  first write address
- ld_len_in  input  PC_Width+1  word count (0 … Mem_Depth)
- ld_valid_in  input  1  ld_data_in valid
- ld_data_in  input  Instr_Width  program word
- ld_ready_out  output  1  load beat accepted when ld_valid_in & ld_ready_out
- ld_busy_out  output  1  loader in LOAD
- ld_done_out  output  1  one-cycle pulse: burst complete
- ld_err_out  output  1  one-cycle pulse: start rejected

## Operation
- Storage: Mem_Depth × Instr_Width array, not reset; contents survive rst_in.
- Loader FSM has two states, IDLE and LOAD.
  - IDLE → LOAD: on ld_start_in with ld_base_in < Mem_Depth, 0 < ld_len_in ≤ Mem_Depth. Latch wptr = ld_base_in and remaining count = ld_len_in.
  - ld_start_in with ld_len_in = 0: stay in IDLE; ld_done_out pulses the next cycle.
  - ld_start_in with ld_base_in ≥ Mem_Depth or ld_len_in > Mem_Depth: stay in IDLE; ld_err_out pulses; memory is not written.
  - In LOAD, ld_ready_out = 1 and ld_busy_out = 1. Each accepted beat writes mem[wptr] and decrements the count. wptr increments and wraps Mem_Depth−1 → 0.
  - The beat that brings the count to 0 returns the FSM to IDLE, and ld_done_out pulses on the following cycle.
  - ld_start_in during LOAD is ignored.
  - ld_valid_in in IDLE is ignored; no write occurs.
- Fetch path: one registered stage, evaluated per cycle with priority rst_in > flush_in > stall_in > fetch.
  - flush_in: cus19_instr_out ← NOP_Instr, instr_valid_out ← 0.
  - stall_in (no flush): all fetch outputs hold.
  - fetch_en_in with FSM in IDLE and pc_in < Mem_Depth: cus19_instr_out ← mem[pc_in], instr_valid_out ← 1.
  - fetch_en_in with FSM in IDLE and pc_in ≥ Mem_Depth: cus19_instr_out ← NOP_Instr, instr_valid_out ← 1, fetch_err_out pulses.
  - fetch_en_in while in LOAD: the fetch is refused; instr_valid_out ← 0 and cus19_instr_out holds.
  - No fetch_en_in: instr_valid_out ← 0 and cus19_instr_out holds.
- A fetch and a load write are never concurrent, so read-during-write is undefined only via misuse, which the FSM gating excludes.

## Timing
- Reset values:
  - cus19_instr_out = 0, instr_valid_out = 0, fetch_err_out = 0
  - ld_ready_out = 0, ld_busy_out = 0, ld_done_out = 0, ld_err_out = 0
  - FSM = IDLE; wptr and count cleared
- Fetch latency is 1 cycle: pc_in sampled at edge N appears on cus19_instr_out after edge N.
- ld_ready_out and ld_busy_out rise the cycle after an accepted ld_start_in. They fall the cycle after the last beat, the same cycle ld_done_out is high.
- Throughput: one load beat per cycle at full rate; one fetch per cycle.
- rst_in mid-LOAD aborts the burst. Already-written words remain; there is no done pulse.
- A fetch in the same cycle the FSM leaves LOAD is still refused. The first valid fetch is sampled in the ld_done_out cycle.

## Test plan
- Load base 0, len 4, data 0x00011/0x00022/0x00033/0x00044 at full rate, then fetch pc 0..3 → outputs 0x00011…0x00044 one cycle after each pc, valid=1; ld_done_out pulses once.
- Mem_Depth=1024, load base 1022, len 4 → words land at 1022, 1023, 0, 1; fetch pc 1030 → NOP, valid=1, fetch_err_out one pulse.
- ld_valid_in toggled 1,0,1,0 during len=2 burst → exactly two writes; ld_busy_out spans the whole burst; fetch requested during the burst → valid=0.
- During steady fetch, assert stall_in 2 cycles → output and valid frozen; then flush_in with stall_in → NOP_Instr, valid=0 (flush wins).
- ld_start_in with len=0 → only ld_done_out pulses. Base=Mem_Depth → only ld_err_out pulses, memory unchanged.
- rst_in after 2 of 5 beats → FSM IDLE, all outputs at reset values, no ld_done_out; the 2 written words are readable after reset.

Source files
------------

// File: rtl/cus19_instr_mem_ld.sv
// Custom19 IF-stage instruction memory with an on-chip program-load stream port.
// A registered fetch stage is gated off while the loader FSM owns the array.
module cus19_instr_mem_ld #(
  parameter int PC_Width    = 11,
  parameter int Instr_Width = 19,
  parameter int Mem_Depth   = 2048,
  parameter logic [Instr_Width-1:0] NOP_Instr = '0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [PC_Width-1:0]    pc_in,
  input  logic                   fetch_en_in,
  input  logic                   stall_in,
  input  logic                   flush_in,
  output logic [Instr_Width-1:0] cus19_instr_out,
  output logic                   instr_valid_out,
  output logic                   fetch_err_out,
  input  logic                   ld_start_in,
  input  logic [PC_Width-1:0]    ld_base_in,
  input  logic [PC_Width:0]      ld_len_in,
  input  logic                   ld_valid_in,
  input  logic [Instr_Width-1:0] ld_data_in,
  output logic                   ld_ready_out,
  output logic                   ld_busy_out,
  output logic                   ld_done_out,
  output logic                   ld_err_out
);

  localparam int AW = (Mem_Depth > 1) ? $clog2(Mem_Depth) : 1;
  localparam logic [PC_Width:0] DEPTH = (PC_Width+1)'(Mem_Depth);
  localparam logic [AW-1:0] LAST = AW'(Mem_Depth - 1);
  localparam logic [PC_Width:0] ONE = (PC_Width+1)'(1);

  typedef enum logic {IDLE, LOAD} ld_state_t;

  logic [Instr_Width-1:0] mem [Mem_Depth];

  ld_state_t         state, state_nxt;
  logic [AW-1:0]     wptr, wptr_nxt;
  logic [PC_Width:0] count, count_nxt;
  logic              done_nxt, err_nxt;
  logic              base_ok, pc_ok, beat;

  assign base_ok = {1'b0, ld_base_in} < DEPTH;
  assign pc_ok   = {1'b0, pc_in} < DEPTH;
  assign beat    = (state == LOAD) && ld_valid_in;

  assign ld_ready_out = (state == LOAD);
  assign ld_busy_out  = (state == LOAD);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      wptr        <= '0;
      count       <= '0;
      ld_done_out <= 1'b0;
      ld_err_out  <= 1'b0;
    end else begin
      state       <= state_nxt;
      wptr        <= wptr_nxt;
      count       <= count_nxt;
      ld_done_out <= done_nxt;
      ld_err_out  <= err_nxt;
    end
  end

  // A bad base/length is rejected before the zero-length shortcut is considered.
  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    count_nxt = count;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start_in) begin
          if (!base_ok || (ld_len_in > DEPTH)) begin
            err_nxt = 1'b1;
          end else if (ld_len_in == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = LOAD;
            wptr_nxt  = ld_base_in[AW-1:0];
            count_nxt = ld_len_in;
          end
        end
      end
      LOAD: begin
        if (ld_valid_in) begin
          wptr_nxt  = (wptr == LAST) ? '0 : wptr + AW'(1);
          count_nxt = count - ONE;
          if (count == ONE) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is deliberately not reset so a loaded program survives rst_in.
  always_ff @(posedge clk_in) begin
    if (!rst_in && beat) begin
      mem[wptr] <= ld_data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cus19_instr_out <= '0;
      instr_valid_out <= 1'b0;
      fetch_err_out   <= 1'b0;
    end else begin
      fetch_err_out <= 1'b0;
      if (flush_in) begin
        cus19_instr_out <= NOP_Instr;
        instr_valid_out <= 1'b0;
      end else if (stall_in) begin
        cus19_instr_out <= cus19_instr_out;
        instr_valid_out <= instr_valid_out;
      end else if (fetch_en_in && (state == IDLE)) begin
        instr_valid_out <= 1'b1;
        if (pc_ok) begin
          cus19_instr_out <= mem[pc_in[AW-1:0]];
        end else begin
          cus19_instr_out <= NOP_Instr;
          fetch_err_out   <= 1'b1;
        end
      end else begin
        instr_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cus19_instr_mem_ld.sv
// Self-checking bench for cus19_instr_mem_ld: directed scenarios plus randomized
// loads and fetches checked against an address-indexed memory model.
module tb_cus19_instr_mem_ld;

  localparam int PW    = 11;
  localparam int IW    = 19;
  localparam int DEPTH = 1024;
  localparam logic [IW-1:0] NOP = 19'h5A5A5;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [PW-1:0] pc_in;
  logic          fetch_en_in, stall_in, flush_in;
  logic [IW-1:0] cus19_instr_out;
  logic          instr_valid_out, fetch_err_out;
  logic          ld_start_in;
  logic [PW-1:0] ld_base_in;
  logic [PW:0]   ld_len_in;
  logic          ld_valid_in;
  logic [IW-1:0] ld_data_in;
  logic          ld_ready_out, ld_busy_out, ld_done_out, ld_err_out;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] model_mem [DEPTH];
  bit            known [DEPTH];
  int            known_q [$];

  cus19_instr_mem_ld #(
    .PC_Width(PW), .Instr_Width(IW), .Mem_Depth(DEPTH), .NOP_Instr(NOP)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pc_in(pc_in), .fetch_en_in(fetch_en_in),
    .stall_in(stall_in), .flush_in(flush_in), .cus19_instr_out(cus19_instr_out),
    .instr_valid_out(instr_valid_out), .fetch_err_out(fetch_err_out),
    .ld_start_in(ld_start_in), .ld_base_in(ld_base_in), .ld_len_in(ld_len_in),
    .ld_valid_in(ld_valid_in), .ld_data_in(ld_data_in), .ld_ready_out(ld_ready_out),
    .ld_busy_out(ld_busy_out), .ld_done_out(ld_done_out), .ld_err_out(ld_err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    pc_in = '0; fetch_en_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    ld_start_in = 1'b0; ld_base_in = '0; ld_len_in = '0;
    ld_valid_in = 1'b0; ld_data_in = '0;
  endtask

  function automatic void model_write(input int addr, input logic [IW-1:0] data);
    model_mem[addr] = data;
    if (!known[addr]) known_q.push_back(addr);
    known[addr] = 1'b1;
  endfunction

  // Drives a full burst; words land at (base + i) mod DEPTH in the model.
  task automatic run_load(input int base, input int len, input bit gaps, input bit fixed);
    int sent, cycles;
    bit v;
    ld_start_in = 1'b1; ld_base_in = PW'(base); ld_len_in = (PW+1)'(len);
    tick();
    ld_start_in = 1'b0;
    checks++;
    if (ld_busy_out !== 1'b1 || ld_ready_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_busy_rise: got busy=%b ready=%b required 1/1", ld_busy_out, ld_ready_out);
    end
    sent = 0; cycles = 0;
    while (sent < len && cycles < 4*len + 20) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_valid_in = v;
      ld_data_in  = fixed ? IW'(17*(sent+1)) : IW'($urandom);
      if (v) begin
        model_write((base + sent) % DEPTH, ld_data_in);
        sent++;
      end
      tick();
      cycles++;
      if (sent < len) begin
        checks++;
        if (ld_busy_out !== 1'b1 || ld_done_out !== 1'b0) begin
          errors++;
          $display("[TB] FAIL load_busy_hold: got busy=%b done=%b required 1/0", ld_busy_out, ld_done_out);
        end
      end
    end
    ld_valid_in = 1'b0;
    checks++;
    if (sent != len) begin
      errors++;
      $display("[TB] FAIL load_timeout: got %0d beats required %0d", sent, len);
    end
    checks++;
    if (ld_done_out !== 1'b1 || ld_busy_out !== 1'b0 || ld_ready_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done: got done=%b busy=%b ready=%b required 1/0/0",
               ld_done_out, ld_busy_out, ld_ready_out);
    end
    tick();
    checks++;
    if (ld_done_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done_pulse: got done=%b required 0", ld_done_out);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
    checks++;
    if (cus19_instr_out !== '0 || instr_valid_out !== 1'b0 || fetch_err_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_fetch: got instr=%h valid=%b err=%b required 0/0/0",
               cus19_instr_out, instr_valid_out, fetch_err_out);
    end
    checks++;
    if ({ld_ready_out, ld_busy_out, ld_done_out, ld_err_out} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_load: got rdy/busy/done/err=%b required 0000",
               {ld_ready_out, ld_busy_out, ld_done_out, ld_err_out});
    end
  endtask

  task automatic test_basic_load();
    run_load(0, 4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      pc_in = PW'(i); fetch_en_in = 1'b1;
      tick();
      checks++;
      if (cus19_instr_out !== IW'(17*(i+1)) || instr_valid_out !== 1'b1 || fetch_err_out !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_fetch pc=%0d: got %h/%b/%b required %h/1/0", i,
                 cus19_instr_out, instr_valid_out, fetch_err_out, IW'(17*(i+1)));
      end
    end
    fetch_en_in = 1'b0;
  endtask

  task automatic test_wrap();
    int pcs [4] = '{1022, 1023, 0, 1};
    run_load(1022, 4, 1'b0, 1'b0);
    foreach (pcs[i]) begin
      pc_in = PW'(pcs[i]); fetch_en_in = 1'b1;
      tick();
      checks++;
      if (cus19_instr_out !== model_mem[pcs[i]] || instr_valid_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL wrap_fetch pc=%0d: got %h/%b required %h/1", pcs[i],
                 cus19_instr_out, instr_valid_out, model_mem[pcs[i]]);
      end
    end
    pc_in = PW'(1030);
    tick();
    checks++;
    if (cus19_instr_out !== NOP || instr_valid_out !== 1'b1 || fetch_err_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oob_fetch: got %h/%b/%b required %h/1/1",
               cus19_instr_out, instr_valid_out, fetch_err_out, NOP);
    end
    fetch_en_in = 1'b0;
    tick();
    checks++;
    if (fetch_err_out !== 1'b0 || instr_valid_out !== 1'b0 || cus19_instr_out !== NOP) begin
      errors++;
      $display("[TB] FAIL oob_pulse: got %h/%b/%b required %h/0/0",
               cus19_instr_out, instr_valid_out, fetch_err_out, NOP);
    end
  endtask

  task automatic test_valid_gaps();
    logic [IW-1:0] d0, d1, old2;
    d0 = IW'($urandom); d1 = IW'($urandom); old2 = model_mem[2];
    ld_start_in = 1'b1; ld_base_in = '0; ld_len_in = (PW+1)'(2);
    tick();
    ld_start_in = 1'b0;
    ld_valid_in = 1'b1; ld_data_in = d0; fetch_en_in = 1'b1; pc_in = PW'(1);
    model_write(0, d0);
    tick();
    checks++;
    if (ld_busy_out !== 1'b1 || instr_valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_beat1: got busy=%b valid=%b required 1/0", ld_busy_out, instr_valid_out);
    end
    ld_valid_in = 1'b0; ld_data_in = IW'($urandom);
    ld_start_in = 1'b1; ld_base_in = PW'(2000); ld_len_in = (PW+1)'(3);
    tick();
    ld_start_in = 1'b0;
    checks++;
    if (ld_busy_out !== 1'b1 || instr_valid_out !== 1'b0 || ld_err_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_idle_beat: got busy=%b valid=%b err=%b required 1/0/0",
               ld_busy_out, instr_valid_out, ld_err_out);
    end
    ld_valid_in = 1'b1; ld_data_in = d1;
    model_write(1, d1);
    tick();
    checks++;
    if (ld_busy_out !== 1'b0 || ld_done_out !== 1'b1 || instr_valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_last_beat: got busy=%b done=%b valid=%b required 0/1/0",
               ld_busy_out, ld_done_out, instr_valid_out);
    end
    ld_valid_in = 1'b0;
    tick();
    checks++;
    if (instr_valid_out !== 1'b1 || cus19_instr_out !== d1 || ld_done_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_first_fetch: got %h/%b done=%b required %h/1 done=0",
               cus19_instr_out, instr_valid_out, ld_done_out, d1);
    end
    pc_in = PW'(2);
    tick();
    checks++;
    if (cus19_instr_out !== old2) begin
      errors++;
      $display("[TB] FAIL gap_no_extra_write: got %h required %h", cus19_instr_out, old2);
    end
    pc_in = PW'(0);
    tick();
    checks++;
    if (cus19_instr_out !== d0) begin
      errors++;
      $display("[TB] FAIL gap_word0: got %h required %h", cus19_instr_out, d0);
    end
    fetch_en_in = 1'b0;
  endtask

  task automatic test_stall_flush();
    fetch_en_in = 1'b1; pc_in = PW'(1022);
    tick();
    pc_in = PW'(3);
    tick();
    stall_in = 1'b1; pc_in = PW'(1023);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (cus19_instr_out !== model_mem[3] || instr_valid_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold cyc=%0d: got %h/%b required %h/1", i,
                 cus19_instr_out, instr_valid_out, model_mem[3]);
      end
    end
    flush_in = 1'b1;
    tick();
    checks++;
    if (cus19_instr_out !== NOP || instr_valid_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_wins: got %h/%b required %h/0", cus19_instr_out, instr_valid_out, NOP);
    end
    idle_inputs();
  endtask

  task automatic test_start_corner();
    ld_start_in = 1'b1; ld_base_in = PW'(5); ld_len_in = '0;
    tick();
    ld_start_in = 1'b0;
    checks++;
    if ({ld_done_out, ld_err_out, ld_busy_out} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL len0: got done/err/busy=%b required 100", {ld_done_out, ld_err_out, ld_busy_out});
    end
    tick();
    checks++;
    if (ld_done_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len0_pulse: got done=%b required 0", ld_done_out);
    end
    ld_start_in = 1'b1; ld_base_in = PW'(DEPTH); ld_len_in = (PW+1)'(3);
    tick();
    ld_start_in = 1'b0;
    checks++;
    if ({ld_done_out, ld_err_out, ld_busy_out} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL bad_base: got done/err/busy=%b required 010", {ld_done_out, ld_err_out, ld_busy_out});
    end
    ld_start_in = 1'b1; ld_base_in = '0; ld_len_in = (PW+1)'(DEPTH + 1);
    tick();
    ld_start_in = 1'b0;
    ld_valid_in = 1'b1; ld_data_in = 19'h7FFFF;
    checks++;
    if ({ld_done_out, ld_err_out, ld_busy_out} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL bad_len: got done/err/busy=%b required 010", {ld_done_out, ld_err_out, ld_busy_out});
    end
    tick(); tick();
    ld_valid_in = 1'b0;
    checks++;
    if ({ld_err_out, ld_busy_out} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL err_pulse: got err/busy=%b required 00", {ld_err_out, ld_busy_out});
    end
    for (int i = 0; i < 4; i++) begin
      pc_in = PW'(i); fetch_en_in = 1'b1;
      tick();
      checks++;
      if (cus19_instr_out !== model_mem[i]) begin
        errors++;
        $display("[TB] FAIL mem_unchanged pc=%0d: got %h required %h", i, cus19_instr_out, model_mem[i]);
      end
    end
    fetch_en_in = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [IW-1:0] d [2];
    ld_start_in = 1'b1; ld_base_in = PW'(100); ld_len_in = (PW+1)'(5);
    tick();
    ld_start_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d[i] = IW'($urandom);
      ld_valid_in = 1'b1; ld_data_in = d[i];
      model_write(100 + i, d[i]);
      tick();
    end
    ld_valid_in = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    checks++;
    if ({ld_ready_out, ld_busy_out, ld_done_out, ld_err_out, instr_valid_out, fetch_err_out} !== 6'b0
        || cus19_instr_out !== '0) begin
      errors++;
      $display("[TB] FAIL abort_reset: got flags=%b instr=%h required 000000/0",
               {ld_ready_out, ld_busy_out, ld_done_out, ld_err_out, instr_valid_out, fetch_err_out},
               cus19_instr_out);
    end
    tick();
    checks++;
    if (ld_done_out !== 1'b0 || ld_busy_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got done=%b busy=%b required 0/0", ld_done_out, ld_busy_out);
    end
    for (int i = 0; i < 2; i++) begin
      pc_in = PW'(100 + i); fetch_en_in = 1'b1;
      tick();
      checks++;
      if (cus19_instr_out !== d[i] || instr_valid_out !== 1'b1) begin
        errors++;
        $display("[TB] FAIL abort_kept pc=%0d: got %h/%b required %h/1", 100+i,
                 cus19_instr_out, instr_valid_out, d[i]);
      end
    end
    fetch_en_in = 1'b0;
  endtask

  task automatic test_random();
    logic [IW-1:0] exp_instr;
    bit exp_valid, exp_err;
    int r, pc;
    for (int i = 0; i < 4; i++) begin
      run_load($urandom_range(0, DEPTH-1), $urandom_range(1, 40), 1'b1, 1'b0);
    end
    pc = known_q[0];
    pc_in = PW'(pc); fetch_en_in = 1'b1;
    tick();
    exp_instr = model_mem[pc]; exp_valid = 1'b1; exp_err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      fetch_en_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0; pc_in = PW'($urandom);
      if (r <= 5) begin
        pc = known_q[$urandom_range(0, known_q.size()-1)];
        pc_in = PW'(pc); fetch_en_in = 1'b1;
        exp_instr = model_mem[pc]; exp_valid = 1'b1; exp_err = 1'b0;
      end else if (r == 6) begin
        pc_in = PW'($urandom_range(DEPTH, 2047)); fetch_en_in = 1'b1;
        exp_instr = NOP; exp_valid = 1'b1; exp_err = 1'b1;
      end else if (r == 7) begin
        exp_valid = 1'b0; exp_err = 1'b0;
      end else if (r == 8) begin
        stall_in = 1'b1; fetch_en_in = 1'($urandom_range(0, 1));
      end else begin
        flush_in = 1'b1; stall_in = 1'($urandom_range(0, 1)); fetch_en_in = 1'($urandom_range(0, 1));
        exp_instr = NOP; exp_valid = 1'b0; exp_err = 1'b0;
      end
      tick();
      checks++;
      if (cus19_instr_out !== exp_instr || instr_valid_out !== exp_valid) begin
        errors++;
        $display("[TB] FAIL rand_fetch i=%0d mode=%0d: got %h/%b required %h/%b", i, r,
                 cus19_instr_out, instr_valid_out, exp_instr, exp_valid);
      end
      if (r != 8) begin
        checks++;
        if (fetch_err_out !== exp_err) begin
          errors++;
          $display("[TB] FAIL rand_err i=%0d: got %b required %b", i, fetch_err_out, exp_err);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    $display("[TB] starting cus19_instr_mem_ld bench");
    test_reset();
    test_basic_load();
    test_wrap();
    test_valid_gaps();
    test_stall_flush();
    test_start_corner();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
